// File: rtl/diff_pkg.sv
// Shared types and mod-4 arithmetic for the differential word encoder/decoder pair.
// Pure declarations, no latency.
// No handshake; consumers own their own flow control.
package diff_pkg;

    typedef logic [1:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Sum of two base-4 digits; the 2-bit result drops any carry, giving mod 4.
    function automatic digit_t mod4_add(input digit_t a, input digit_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/undiff_word_seq_if.sv
// Word-in / word-out handshake bundle for the sequential differential decoder.
// No logic, no latency.
// Valid/ready on both sides; master is the producer/consumer, slave is the decoder.
interface undiff_word_seq_if #(
    parameter int N = 100
);
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] word_in;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] word_out;
    logic           busy;

    modport master (
        output in_valid, word_in, out_ready,
        input  in_ready, out_valid, word_out, busy
    );

    modport slave (
        input  in_valid, word_in, out_ready,
        output in_ready, out_valid, word_out, busy
    );
endinterface

// File: rtl/diff_chunk_acc.sv
// Running mod-4 prefix sum over P digits, most significant digit first, seeded by i_acc.
// Purely combinational, zero latency.
// No handshake; the caller decides when to sample the result.
module diff_chunk_acc
    import diff_pkg::*;
#(
    parameter int P = 4
) (
    input  digit_t         i_acc,
    input  logic [2*P-1:0] i_dig,
    output logic [2*P-1:0] o_dig,
    output digit_t         o_acc
);

    digit_t w_run;

    // Chain the digits from the top down; each decoded digit seeds the next one.
    always_comb begin
        w_run = i_acc;
        o_dig = '0;
        for (int j = P - 1; j >= 0; j--) begin
            w_run             = mod4_add(w_run, i_dig[2*j +: 2]);
            o_dig[2*j +: 2]   = w_run;
        end
        o_acc = w_run;
    end

endmodule

// File: rtl/undiff_word_seq.sv
// Sequential differential-word decoder: P base-4 digits per cycle, MSB chunk first.
// Latency N/P cycles from acceptance to out_valid; one word in flight at a time.
// in_ready only in IDLE; result held in DONE until out_ready, then back to IDLE.
module undiff_word_seq
    import diff_pkg::*;
#(
    parameter int N = 100,
    parameter int P = 4
) (
    input  logic                clk,
    input  logic                rst,
    undiff_word_seq_if.slave    bus
);

    localparam int             NC   = N / P;
    localparam int             CW   = $clog2(NC + 1);
    localparam logic [CW-1:0]  LAST = CW'(NC - 1);

    generate
        if (P < 1 || (N % P) != 0) begin : g_bad_cfg
            $error("undiff_word_seq: N must be a positive multiple of P");
        end
    endgenerate

    state_t          r_state;
    state_t          w_next;
    logic [2*N-1:0]  r_cap;
    logic [2*N-1:0]  r_res;
    logic [2*N-1:0]  r_word_out;
    logic [2*N-1:0]  w_res_next;
    digit_t          r_acc;
    digit_t          w_acc_next;
    logic [CW-1:0]   r_cnt;
    logic [2*P-1:0]  w_chunk_out;
    logic            w_accept;
    logic            w_last;
    logic            w_deliver;

    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_last    = (r_state == ST_RUN) && (r_cnt == LAST);
    assign w_deliver = bus.out_valid && bus.out_ready;

    // The capture register is shifted left each RUN cycle, so the next chunk is always at the top.
    diff_chunk_acc #(.P(P)) u_chunk (
        .i_acc (r_acc),
        .i_dig (r_cap[2*N-1 -: 2*P]),
        .o_dig (w_chunk_out),
        .o_acc (w_acc_next)
    );

    // Decoded chunks enter at the bottom and migrate up; after NC chunks the first one sits at the MSBs.
    assign w_res_next = (r_res << (2*P)) | (2*N)'(w_chunk_out);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: if (w_deliver) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Handshake and status outputs follow the state directly.
    always_comb begin
        bus.in_ready  = (r_state == ST_IDLE);
        bus.out_valid = (r_state == ST_DONE);
        bus.busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    end

    assign bus.word_out = r_word_out;

    // Datapath: capture on acceptance, decode one chunk per RUN cycle, publish on the final chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap      <= '0;
            r_res      <= '0;
            r_word_out <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else begin
            if (r_state == ST_IDLE && w_accept) begin
                r_cap <= bus.word_in;
                r_res <= '0;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_cap <= r_cap << (2*P);
                r_res <= w_res_next;
                r_acc <= w_acc_next;
                if (w_last) r_word_out <= w_res_next;
                else        r_cnt      <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_undiff_word_seq.sv
// Directed vectors on an N=4/P=2 decoder plus a 1000-word round trip on an N=100/P=4 decoder.
// Expected values are hand-computed or produced by a bench-side differential encoder.
module tb_undiff_word_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    undiff_word_seq_if #(.N(4))   bs ();
    undiff_word_seq_if #(.N(100)) bb ();

    undiff_word_seq #(.N(4),   .P(2)) u_small (.clk(clk), .rst(rst), .bus(bs));
    undiff_word_seq #(.N(100), .P(4)) u_big   (.clk(clk), .rst(rst), .bus(bb));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] win;
        logic [7:0] wexp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one word to the small decoder and wait for its result; leaves it in DONE.
    task automatic send_small(input logic [7:0] w, input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bs.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, 256'(bs.in_ready), 256'(1));
        bs.word_in  = w;
        bs.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bs.in_valid = 1'b0;
        bs.word_in  = ~w;
        chk({tag, "_busy"}, 256'({bs.busy, bs.in_ready}), 256'(2'b10));
        n = 0;
        while (!bs.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 256'(n), 256'(2));
        chk({tag, "_dat"}, 256'(bs.word_out), 256'(exp));
    endtask

    task automatic drain_small(input string tag);
        bs.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bs.out_ready = 1'b0;
        chk({tag, "_drain"}, 256'({bs.out_valid, bs.in_ready, bs.busy}), 256'(3'b010));
    endtask

    logic [199:0] orig, enc;
    logic [1:0]   dd;
    int           n;
    bit           seen;

    initial begin
        vecs[0] = '{win: 8'h66, wexp: 8'h72};
        vecs[1] = '{win: 8'hFF, wexp: 8'hE4};
        vecs[2] = '{win: 8'hC0, wexp: 8'hFF};
        vecs[3] = '{win: 8'h00, wexp: 8'h00};
        vecs[4] = '{win: 8'h1B, wexp: 8'h1E};
        vecs[5] = '{win: 8'h55, wexp: 8'h6C};

        bs.in_valid = 1'b0; bs.word_in = '0; bs.out_ready = 1'b0;
        bb.in_valid = 1'b0; bb.word_in = '0; bb.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_small", 256'({bs.out_valid, bs.busy, bs.word_out}), 256'(0));
        chk("rst_big_out", 256'(bb.word_out), 256'(0));
        chk("rst_big_flags", 256'({bb.out_valid, bb.busy}), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rdy", 256'({bs.in_ready, bb.in_ready}), 256'(2'b11));

        // Table of directed words.
        for (int i = 0; i < 6; i++) begin
            send_small(vecs[i].win, vecs[i].wexp, $sformatf("vec%0d", i));
            drain_small($sformatf("vec%0d", i));
        end

        // Consumer stalls for 5 cycles while a new word is offered.
        send_small(8'h1B, 8'h1E, "stall");
        bs.in_valid = 1'b1;
        bs.word_in  = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall_hold%0d", k),
                256'({bs.out_valid, bs.in_ready, bs.busy, bs.word_out}),
                256'({1'b1, 1'b0, 1'b1, 8'h1E}));
        end
        bs.in_valid = 1'b0;
        drain_small("stall");
        chk("stall_keep", 256'(bs.word_out), 256'(8'h1E));

        // Reset lands in RUN: the word is dropped and no result ever appears.
        @(negedge clk);
        bs.word_in  = 8'hC0;
        bs.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bs.in_valid = 1'b0;
        chk("rstrun_inrun", 256'(bs.busy), 256'(1));
        rst = 1'b1;
        #1;
        chk("rstrun_out", 256'({bs.out_valid, bs.busy, bs.word_out}), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bs.out_valid) seen = 1'b1;
        end
        chk("rstrun_novld", 256'(seen), 256'(0));
        send_small(8'h66, 8'h72, "after_rst");
        drain_small("after_rst");

        // Round trip on the wide instance through a bench-side encoder.
        bb.out_ready = 1'b1;
        for (int w = 0; w < 1000; w++) begin
            for (int b = 0; b < 200; b++) orig[b] = 1'($urandom_range(0, 1));
            for (int d = 0; d < 100; d++) begin
                if (d == 99) dd = orig[2*d +: 2];
                else         dd = orig[2*d +: 2] - orig[2*(d+1) +: 2];
                enc[2*d +: 2] = dd;
            end
            n = 0;
            @(negedge clk);
            while (!bb.in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!bb.in_ready) begin
                chk($sformatf("rt%0d_rdy", w), 256'(bb.in_ready), 256'(1));
                break;
            end
            bb.word_in  = enc;
            bb.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bb.in_valid = 1'b0;
            bb.word_in  = ~enc;
            n = 0;
            while (!bb.out_valid && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk($sformatf("rt%0d_lat", w), 256'(n), 256'(25));
            chk($sformatf("rt%0d_dat", w), 256'(bb.word_out), 256'(orig));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/undiff_word_seq.md
UNDIFF_WORD_SEQ -- requirements
Module: undiff_word_seq

Interface
REQ-001 Parameter N, default 100: number of base-4 digits per word (2 bits each, digit N-1 at MSBs).
REQ-002 Parameter P, default 4: digits decoded per cycle; N % P == 0 SHALL be an elaboration-time check.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  word_in holds a differential word.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 word_in  input  2*N  differential-encoded word.
REQ-008 out_valid  output  1  word_out holds a decoded word.
REQ-009 out_ready  input  1  consumer takes word_out this cycle.
REQ-010 word_out  output  2*N  decoded (original) word.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 Decoding is the inverse of the team's differential encoder: out[N-1] = in[N-1]; out[i] = (out[i+1] + in[i]) mod 4 for i = N-2 down to 0.
REQ-013 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready edge, capture word_in, clear accumulator (2 bits) to 0, clear chunk counter, go to RUN.
REQ-015 RUN: in_ready=0; each cycle decode next P digits, MSB chunk first, with acc seeding digit chain: d = (acc + in_digit) mod 4, acc <= last digit of chunk.
REQ-016 RUN lasts exactly N/P cycles; on the edge completing chunk N/P-1, the full result is loaded into word_out and state goes to DONE.
REQ-017 Latency: out_valid rises N/P cycles after the acceptance edge (P=N gives 1 cycle).
REQ-018 DONE: out_valid=1, word_out stable; leave to IDLE on out_valid&&out_ready edge; in_ready returns high the following cycle (no overlap, max throughput 1 word per N/P+2 cycles).
REQ-019 in_valid during RUN/DONE ignored; word_in changes after acceptance have no effect.
REQ-020 word_out updates only on RUN->DONE; otherwise holds the last result.
REQ-021 Arithmetic mod 4 by 2-bit truncation of the sum; no carry beyond 2 bits.
REQ-022 Chunk counter width $clog2(N/P+1); no wrap past N/P-1.

Reset
REQ-023 rst asserted: state IDLE, word_out=0, out_valid=0, busy=0, accumulator/counter/capture reg=0, in_ready=1 after rst deasserts.
REQ-024 rst mid-RUN or mid-DONE aborts the word; no out_valid is produced for it.

Structure
REQ-025 Shared package diff_pkg: digit_t (logic [1:0]), state enum, mod4_add function; shared with the encoder.
REQ-026 One combinational sub-module diff_chunk_acc: P-digit prefix-sum mod 4 with carry-in acc, outputs P digits and carry-out acc.
REQ-027 Implementation size target 120-400 lines.

Verification (N=4, P=2 unless stated)
REQ-028 word_in=8'h66 (digits 1,2,1,2) -> word_out=8'h72 (1,3,0,2), out_valid 2 cycles after acceptance.
REQ-029 word_in=8'hFF -> 8'hE4; word_in=8'hC0 -> 8'hFF; word_in=8'h00 -> 8'h00 (wrap-around coverage).
REQ-030 out_ready held low 5 cycles in DONE -> out_valid, word_out stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-031 rst pulse during RUN -> outputs 0, no out_valid; next word 8'h66 decodes to 8'h72 correctly.
REQ-032 N=100, P=4: 1000 random words through the encoder then this block -> exact round-trip, out_valid exactly 25 cycles after each acceptance.
